// File: rtl/fadd_sched_pkg.sv
// Shared definitions for the two-port floating-point add scheduler:
// pipeline depth, operand width, the response tag type and a tag helper.
package fadd_sched_pkg;

  localparam int FADD_LAT = 3;
  localparam int FLOAT_W  = 32;

  // Canonical quiet NaN returned for invalid additions (NaN input, inf - inf).
  localparam logic [FLOAT_W-1:0] FLOAT_QNAN = 32'h7FC0_0000;

  // One tag travels alongside each operation through the adder pipeline so the
  // result can be steered back to the port that issued it.
  typedef struct packed {
    logic valid;
    logic id;
  } tag_t;

  function automatic tag_t makeTag(input logic valid, input logic id);
    tag_t t;
    t.valid = valid;
    t.id    = id;
    return t;
  endfunction

endpackage

// File: rtl/fadd_sched_fadd.sv
// Pipelined IEEE-754 single-precision adder (round to nearest even).
// The sum is computed combinationally from the operands and then carried
// through LAT register stages, so a result appears LAT cycles after its inputs.
module fadd
  import fadd_sched_pkg::*;
#(
  parameter int LAT = FADD_LAT
) (
  input  logic               i_clk,
  input  logic               i_rst_n,
  input  logic [FLOAT_W-1:0] i_op1,
  input  logic [FLOAT_W-1:0] i_op2,
  output logic [FLOAT_W-1:0] o_result
);

  logic               w_swap;
  logic               w_effSub;
  logic [FLOAT_W-1:0] w_big;
  logic [FLOAT_W-1:0] w_small;
  logic [7:0]         w_expBig;
  logic [7:0]         w_expSmall;
  logic [7:0]         w_expDiff;
  logic [23:0]        w_manBig;
  logic [23:0]        w_manSmall;
  logic [53:0]        w_alignWide;
  logic [26:0]        w_alignSmall;
  logic [27:0]        w_raw;
  logic [4:0]         w_lz;
  logic [4:0]         w_shift;
  logic [26:0]        w_norm;
  logic [9:0]         w_expNorm;
  logic               w_roundUp;
  logic [24:0]        w_rounded;
  logic [9:0]         w_expRound;
  logic [22:0]        w_fracOut;
  logic               w_nan1;
  logic               w_nan2;
  logic               w_inf1;
  logic               w_inf2;
  logic [FLOAT_W-1:0] w_sum;

  logic [FLOAT_W-1:0] r_pipe [LAT];

  // Order operands by magnitude so the subtraction path never goes negative.
  assign w_swap  = i_op2[30:0] > i_op1[30:0];
  assign w_big   = w_swap ? i_op2 : i_op1;
  assign w_small = w_swap ? i_op1 : i_op2;

  // Denormals use an effective exponent of 1 and no hidden bit.
  assign w_expBig   = (w_big[30:23] == 8'd0) ? 8'd1 : w_big[30:23];
  assign w_expSmall = (w_small[30:23] == 8'd0) ? 8'd1 : w_small[30:23];
  assign w_manBig   = {|w_big[30:23], w_big[22:0]};
  assign w_manSmall = {|w_small[30:23], w_small[22:0]};
  assign w_expDiff  = w_expBig - w_expSmall;

  // Align the smaller mantissa; bits shifted past the guard/round positions
  // fold into a single sticky bit.
  assign w_alignWide  = {w_manSmall, 30'd0} >> ((w_expDiff > 8'd27) ? 8'd27 : w_expDiff);
  assign w_alignSmall = {w_alignWide[53:28], w_alignWide[27] | (|w_alignWide[26:0])};

  assign w_effSub = w_big[31] ^ w_small[31];
  assign w_raw    = w_effSub ? ({1'b0, w_manBig, 3'b000} - {1'b0, w_alignSmall})
                             : ({1'b0, w_manBig, 3'b000} + {1'b0, w_alignSmall});

  // Leading-zero count of the 27-bit magnitude (27 when it is all zero).
  always_comb begin
    w_lz = 5'd27;
    for (int i = 0; i < 27; i++) begin
      if (w_raw[i]) w_lz = 5'(26 - i);
    end
  end

  // Normalize: shift right on carry-out, otherwise left until the hidden bit
  // is set or the exponent bottoms out in the denormal range.
  always_comb begin
    w_shift   = 5'd0;
    w_norm    = w_raw[26:0];
    w_expNorm = {2'b00, w_expBig};
    if (w_raw[27]) begin
      w_norm    = {w_raw[27:2], w_raw[1] | w_raw[0]};
      w_expNorm = {2'b00, w_expBig} + 10'd1;
    end else begin
      if (w_expBig > {3'b000, w_lz}) w_shift = w_lz;
      else                           w_shift = 5'(w_expBig - 8'd1);
      w_norm    = w_raw[26:0] << w_shift;
      w_expNorm = {2'b00, w_expBig} - {5'b00000, w_shift};
    end
  end

  assign w_nan1 = (&i_op1[30:23]) & (|i_op1[22:0]);
  assign w_nan2 = (&i_op2[30:23]) & (|i_op2[22:0]);
  assign w_inf1 = (&i_op1[30:23]) & ~(|i_op1[22:0]);
  assign w_inf2 = (&i_op2[30:23]) & ~(|i_op2[22:0]);

  // Round to nearest, ties to even, using guard/round/sticky below bit 3.
  assign w_roundUp = w_norm[2] & (w_norm[1] | w_norm[0] | w_norm[3]);
  assign w_rounded = {1'b0, w_norm[26:3]} + {24'd0, w_roundUp};

  // Pack the result, then let zeros, infinities and NaNs override it.
  always_comb begin
    w_expRound = w_expNorm;
    w_fracOut  = w_rounded[22:0];
    if (w_rounded[24]) begin
      w_expRound = w_expNorm + 10'd1;
      w_fracOut  = w_rounded[23:1];
    end
    if (w_expRound >= 10'd255) begin
      w_sum = {w_big[31], 8'hFF, 23'd0};
    end else if (w_rounded[24] | w_rounded[23]) begin
      w_sum = {w_big[31], w_expRound[7:0], w_fracOut};
    end else begin
      w_sum = {w_big[31], 8'd0, w_fracOut};
    end
    if (w_raw == 28'd0) w_sum = {w_big[31] & ~w_effSub, 31'd0};
    if (w_nan1 | w_nan2 | (w_inf1 & w_inf2 & (i_op1[31] ^ i_op2[31]))) begin
      w_sum = FLOAT_QNAN;
    end else if (w_inf1) begin
      w_sum = i_op1;
    end else if (w_inf2) begin
      w_sum = i_op2;
    end
  end

  // Delay line that gives the adder its fixed LAT-cycle latency.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      for (int i = 0; i < LAT; i++) r_pipe[i] <= '0;
    end else begin
      r_pipe[0] <= w_sum;
      for (int i = 1; i < LAT; i++) r_pipe[i] <= r_pipe[i-1];
    end
  end

  assign o_result = r_pipe[LAT-1];

endmodule

// File: rtl/fadd_sched.sv
// Two-port scheduler sharing one pipelined fadd. A round-robin arbiter picks
// at most one requester per cycle; a tag pipeline running in lockstep with the
// adder remembers which port each result belongs to.
module fadd_sched
  import fadd_sched_pkg::*;
#(
  parameter int LAT = FADD_LAT,
  parameter int W   = FLOAT_W
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         req0_valid,
  output logic         req0_ready,
  input  logic [W-1:0] req0_op1,
  input  logic [W-1:0] req0_op2,
  input  logic         req1_valid,
  output logic         req1_ready,
  input  logic [W-1:0] req1_op1,
  input  logic [W-1:0] req1_op2,
  output logic         rsp0_valid,
  output logic         rsp1_valid,
  output logic [W-1:0] rsp_data,
  output logic         idle
);

  tag_t         r_tag [LAT];
  logic         r_lastGrant;
  logic         w_grant0;
  logic         w_grant1;
  logic         w_accept;
  logic         w_grantId;
  logic         w_anyTag;
  logic [W-1:0] w_op1;
  logic [W-1:0] w_op2;
  logic [W-1:0] w_result;

  // Round-robin grant: a lone requester wins, under contention the port that
  // did not win last time wins; nothing is granted while reset is held.
  always_comb begin
    w_grant0 = 1'b0;
    w_grant1 = 1'b0;
    if (reset) begin
      w_grant0 = req0_valid & (~req1_valid | r_lastGrant);
      w_grant1 = req1_valid & (~req0_valid | ~r_lastGrant);
    end
  end

  assign req0_ready = w_grant0;
  assign req1_ready = w_grant1;
  assign w_accept   = w_grant0 | w_grant1;
  assign w_grantId  = w_grant1;

  // Steer the granted port's operands into the adder, zeros when idle.
  always_comb begin
    w_op1 = '0;
    w_op2 = '0;
    if (w_grant0) begin
      w_op1 = req0_op1;
      w_op2 = req0_op2;
    end else if (w_grant1) begin
      w_op1 = req1_op1;
      w_op2 = req1_op2;
    end
  end

  // Remember the last winner; starts at port 1 so port 0 wins first contention.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_lastGrant <= 1'b1;
    end else if (w_accept) begin
      r_lastGrant <= w_grantId;
    end
  end

  // Tag pipeline advances every cycle, matching the adder's latency exactly;
  // clearing it on reset discards any results still inside the adder.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < LAT; i++) r_tag[i] <= makeTag(1'b0, 1'b0);
    end else begin
      r_tag[0] <= makeTag(w_accept, w_grantId);
      for (int i = 1; i < LAT; i++) r_tag[i] <= r_tag[i-1];
    end
  end

  // Any operation still in flight keeps the block busy.
  always_comb begin
    w_anyTag = 1'b0;
    for (int i = 0; i < LAT; i++) begin
      if (r_tag[i].valid) w_anyTag = 1'b1;
    end
  end

  fadd #(
    .LAT(LAT)
  ) u_fadd (
    .i_clk   (clk),
    .i_rst_n (reset),
    .i_op1   (w_op1),
    .i_op2   (w_op2),
    .o_result(w_result)
  );

  assign rsp0_valid = r_tag[LAT-1].valid & ~r_tag[LAT-1].id;
  assign rsp1_valid = r_tag[LAT-1].valid &  r_tag[LAT-1].id;
  assign rsp_data   = w_result;
  assign idle       = reset & ~req0_valid & ~req1_valid & ~w_anyTag;

endmodule

// File: tb/tb_fadd_sched.sv
// Self-checking bench for fadd_sched: directed scenarios plus random traffic,
// compared against a transaction-level model (round-robin rule, a queue of
// expected responses with due cycles, and integer arithmetic for the sums).
module tb_fadd_sched;

  localparam int LAT = 3;
  localparam int W   = 32;

  typedef struct {
    int          due;
    bit          port;
    logic [31:0] data;
  } expRsp_t;

  logic         clk = 1'b0;
  logic         reset = 1'b1;
  logic         req0_valid = 1'b0;
  logic         req0_ready;
  logic [W-1:0] req0_op1 = '0;
  logic [W-1:0] req0_op2 = '0;
  logic         req1_valid = 1'b0;
  logic         req1_ready;
  logic [W-1:0] req1_op1 = '0;
  logic [W-1:0] req1_op2 = '0;
  logic         rsp0_valid;
  logic         rsp1_valid;
  logic [W-1:0] rsp_data;
  logic         idle;

  expRsp_t pending[$];
  int      cyc = 0;
  bit      lastGrant = 1'b1;
  int      errors = 0;
  int      checks = 0;

  // Free-running clock, 10 time units per cycle.
  always #5 clk = ~clk;

  fadd_sched #(
    .LAT(LAT),
    .W  (W)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .req0_valid(req0_valid),
    .req0_ready(req0_ready),
    .req0_op1  (req0_op1),
    .req0_op2  (req0_op2),
    .req1_valid(req1_valid),
    .req1_ready(req1_ready),
    .req1_op1  (req1_op1),
    .req1_op2  (req1_op2),
    .rsp0_valid(rsp0_valid),
    .rsp1_valid(rsp1_valid),
    .rsp_data  (rsp_data),
    .idle      (idle)
  );

  // Exact single-precision encoding of a small integer (|v| < 2^24).
  function automatic logic [31:0] enc(input int v);
    logic [31:0] r;
    int m;
    int e;
    int frac;
    if (v == 0) return 32'h0000_0000;
    r[31] = (v < 0);
    m = (v < 0) ? -v : v;
    e = 0;
    while ((m >> (e + 1)) != 0) e++;
    frac = (m << (23 - e)) - (1 << 23);
    r[30:23] = 8'(127 + e);
    r[22:0]  = 23'(frac);
    return r;
  endfunction

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    assert (observed === expected)
    else begin
      errors++;
      $error("[TB] FAIL %s: observed=%h expected=%h (cycle %0d)", tag, observed, expected, cyc);
    end
  endtask

  // One clock cycle: drive requests just after the edge, check every output
  // against the model mid-cycle, then update the model and cross the edge.
  task automatic applyStimulus(input logic v0, input logic [31:0] a0, input logic [31:0] b0,
                               input logic [31:0] s0, input logic v1, input logic [31:0] a1,
                               input logic [31:0] b1, input logic [31:0] s1);
    bit g0, g1, expR0, expR1, expIdle;
    logic [31:0] expData;
    req0_valid = v0;
    req0_op1   = a0;
    req0_op2   = b0;
    req1_valid = v1;
    req1_op1   = a1;
    req1_op2   = b1;
    @(negedge clk);
    g0 = v0 && (!v1 || lastGrant);
    g1 = v1 && (!v0 || !lastGrant);
    checkOutput("req0_ready", {31'd0, req0_ready}, {31'd0, g0});
    checkOutput("req1_ready", {31'd0, req1_ready}, {31'd0, g1});
    expIdle = !v0 && !v1 && (pending.size() == 0);
    checkOutput("idle", {31'd0, idle}, {31'd0, expIdle});
    expR0   = 1'b0;
    expR1   = 1'b0;
    expData = '0;
    if (pending.size() > 0 && pending[0].due == cyc) begin
      expR0   = (pending[0].port == 1'b0);
      expR1   = (pending[0].port == 1'b1);
      expData = pending[0].data;
      void'(pending.pop_front());
    end
    checkOutput("rsp0_valid", {31'd0, rsp0_valid}, {31'd0, expR0});
    checkOutput("rsp1_valid", {31'd0, rsp1_valid}, {31'd0, expR1});
    if (expR0 || expR1) checkOutput("rsp_data", rsp_data, expData);
    if (g0) begin
      pending.push_back('{due: cyc + LAT, port: 1'b0, data: s0});
      lastGrant = 1'b0;
    end
    if (g1) begin
      pending.push_back('{due: cyc + LAT, port: 1'b1, data: s1});
      lastGrant = 1'b1;
    end
    @(posedge clk);
    cyc++;
    #1;
  endtask

  task automatic idleCycles(input int n);
    for (int i = 0; i < n; i++) applyStimulus(1'b0, '0, '0, '0, 1'b0, '0, '0, '0);
  endtask

  // Assert reset mid-cycle, check all outputs are forced low, hold it for a
  // few edges, and release it just after an edge so the next edge can accept.
  task automatic doReset(input int holdCycles);
    reset      = 1'b0;
    req0_valid = 1'b1;
    req1_valid = 1'b1;
    #1;
    checkOutput("rst_req0_ready", {31'd0, req0_ready}, 32'd0);
    checkOutput("rst_req1_ready", {31'd0, req1_ready}, 32'd0);
    checkOutput("rst_rsp0_valid", {31'd0, rsp0_valid}, 32'd0);
    checkOutput("rst_rsp1_valid", {31'd0, rsp1_valid}, 32'd0);
    checkOutput("rst_idle", {31'd0, idle}, 32'd0);
    pending.delete();
    lastGrant  = 1'b1;
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    for (int i = 0; i < holdCycles; i++) begin
      @(posedge clk);
      cyc++;
      #1;
      checkOutput("rst_idle_held", {31'd0, idle}, 32'd0);
      checkOutput("rst_rsp0_held", {31'd0, rsp0_valid}, 32'd0);
      checkOutput("rst_rsp1_held", {31'd0, rsp1_valid}, 32'd0);
    end
    reset = 1'b1;
  endtask

  initial begin
    int x0, y0, x1, y1;
    $display("[TB] fadd_sched bench starting");
    #2;
    doReset(2);

    // First contention straight out of reset: port 0, then port 1.
    applyStimulus(1'b1, 32'h3F80_0000, 32'h3F80_0000, 32'h4000_0000,
                  1'b1, 32'h4000_0000, 32'h4000_0000, 32'h4080_0000);
    applyStimulus(1'b0, '0, '0, '0,
                  1'b1, 32'h4000_0000, 32'h4000_0000, 32'h4080_0000);
    idleCycles(5);

    // Single op on port 0: 1.0 + 2.0 = 3.0.
    applyStimulus(1'b1, 32'h3F80_0000, 32'h4000_0000, 32'h4040_0000,
                  1'b0, '0, '0, '0);
    idleCycles(5);

    // Sustained contention for 8 cycles: grants and responses alternate.
    for (int i = 0; i < 8; i++) begin
      applyStimulus(1'b1, enc(i), enc(1), enc(i + 1),
                    1'b1, enc(i), enc(10), enc(i + 10));
    end
    idleCycles(6);

    // Back-to-back port 1 only: 1.5 + 1.5 = 3.0, five times.
    for (int i = 0; i < 5; i++) begin
      applyStimulus(1'b0, '0, '0, '0,
                    1'b1, 32'h3FC0_0000, 32'h3FC0_0000, 32'h4040_0000);
    end
    idleCycles(5);

    // Opposite-sign cancellation yields +0 on the issuing port.
    applyStimulus(1'b0, '0, '0, '0,
                  1'b1, 32'h4000_0000, 32'hC000_0000, 32'h0000_0000);
    idleCycles(5);
    applyStimulus(1'b1, 32'h4000_0000, 32'hC000_0000, 32'h0000_0000,
                  1'b0, '0, '0, '0);
    idleCycles(5);

    // Reset one cycle after an accept: the in-flight result must vanish.
    applyStimulus(1'b1, 32'h3F80_0000, 32'h4000_0000, 32'h4040_0000,
                  1'b0, '0, '0, '0);
    idleCycles(1);
    doReset(1);
    idleCycles(5);

    // Random traffic with exactly representable integer operands.
    for (int n = 0; n < 80; n++) begin
      x0 = int'($urandom_range(2000)) - 1000;
      y0 = int'($urandom_range(2000)) - 1000;
      x1 = int'($urandom_range(2000)) - 1000;
      y1 = int'($urandom_range(2000)) - 1000;
      applyStimulus($urandom_range(1) == 1, enc(x0), enc(y0), enc(x0 + y0),
                    $urandom_range(1) == 1, enc(x1), enc(y1), enc(x1 + y1));
    end
    idleCycles(6);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
